// File: rtl/vga_wb_master.sv
// rtl/vga_wb_master.sv - Wishbone burst read master feeding the VGA line FIFO
// Optional registered-feedback cycle tags (CTI_O/BTE_O) under macro VGA_WB_B3_CTI_EN.
module vga_wb_master #(
    parameter int LCNT_W = 22
) (
    input  logic              CLK_I,
    input  logic              nRESET,
    input  logic              ven,
    input  logic              vbsw,
    input  logic [1:0]        vbl,
    input  logic [29:0]       VBARa,
    input  logic [29:0]       VBARb,
    input  logic [LCNT_W-1:0] frame_len,
    input  logic              fifo_nfull,
    output logic              fifo_wreq,
    output logic [31:0]       fifo_d,
    output logic [29:0]       ADR_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic [3:0]        SEL_O,
`ifdef VGA_WB_B3_CTI_EN
    output logic [2:0]        CTI_O,
    output logic [1:0]        BTE_O,
`endif
    input  logic [31:0]       DAT_I,
    input  logic              ACK_I,
    input  logic              ERR_I,
    output logic              avmp,
    output logic              bsint,
    output logic              sint
);

    typedef enum logic [1:0] {IDLE, BURST, ERROR} state_t;

    state_t            state_q;
    logic [LCNT_W-1:0] word_cnt_q;
    logic [3:0]        burst_cnt_q;
    logic [29:0]       adr_q;
    logic [31:0]       fifo_d_q;
    logic              cyc_q, fifo_wreq_q, avmp_q, bsint_q, sint_q;
`ifdef VGA_WB_B3_CTI_EN
    logic [2:0]        cti_q;
`endif

    logic [3:0]        burst_len;
    logic [LCNT_W-1:0] frame_rem;
    logic [3:0]        burst_cnt_d;
    logic              frame_end;
    logic [29:0]       next_base;

    // A burst is clipped to the words left in the frame so it never spans frame end.
    always_comb begin
        burst_len   = 4'd1 << vbl;
        frame_rem   = frame_len - word_cnt_q;
        burst_cnt_d = burst_len;
        if (frame_rem != '0 && frame_rem < LCNT_W'(burst_len))
            burst_cnt_d = frame_rem[3:0];
        frame_end   = (word_cnt_q + LCNT_W'(1)) == frame_len;
        next_base   = (avmp_q ^ vbsw) ? VBARb : VBARa;
    end

    always_ff @(posedge CLK_I or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            adr_q       <= '0;
            fifo_d_q    <= '0;
            cyc_q       <= 1'b0;
            fifo_wreq_q <= 1'b0;
            avmp_q      <= 1'b0;
            bsint_q     <= 1'b0;
            sint_q      <= 1'b0;
`ifdef VGA_WB_B3_CTI_EN
            cti_q       <= 3'b000;
`endif
        end else begin
            fifo_wreq_q <= 1'b0;
            bsint_q     <= 1'b0;
            sint_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ven) begin
                        word_cnt_q <= '0;
                        avmp_q     <= 1'b0;
                        adr_q      <= VBARa;
                    end else if (!fifo_nfull) begin
                        cyc_q       <= 1'b1;
                        burst_cnt_q <= burst_cnt_d;
                        state_q     <= BURST;
`ifdef VGA_WB_B3_CTI_EN
                        cti_q       <= (burst_cnt_d == 4'd1) ? 3'b111 : 3'b010;
`endif
                    end
                end
                BURST: begin
                    if (ERR_I) begin
                        cyc_q   <= 1'b0;
                        sint_q  <= 1'b1;
                        state_q <= ERROR;
`ifdef VGA_WB_B3_CTI_EN
                        cti_q   <= 3'b000;
`endif
                    end else if (ACK_I) begin
                        fifo_wreq_q <= 1'b1;
                        fifo_d_q    <= DAT_I;
                        adr_q       <= adr_q + 30'd1;
                        word_cnt_q  <= word_cnt_q + LCNT_W'(1);
                        burst_cnt_q <= burst_cnt_q - 4'd1;
`ifdef VGA_WB_B3_CTI_EN
                        cti_q       <= (burst_cnt_q == 4'd2) ? 3'b111 : 3'b010;
`endif
                        // Drop CYC on the final ACK so a combinational slave cannot ack again.
                        if (burst_cnt_q == 4'd1) begin
                            cyc_q   <= 1'b0;
                            state_q <= IDLE;
`ifdef VGA_WB_B3_CTI_EN
                            cti_q   <= 3'b000;
`endif
                        end
                        if (frame_end) begin
                            word_cnt_q <= '0;
                            adr_q      <= next_base;
                            if (vbsw) begin
                                avmp_q  <= ~avmp_q;
                                bsint_q <= 1'b1;
                            end
                        end
                    end
                end
                ERROR: begin
                    if (!ven)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ADR_O     = adr_q;
    assign CYC_O     = cyc_q;
    assign STB_O     = cyc_q;
    assign WE_O      = 1'b0;
    assign SEL_O     = 4'b1111;
    assign fifo_wreq = fifo_wreq_q;
    assign fifo_d    = fifo_d_q;
    assign avmp      = avmp_q;
    assign bsint     = bsint_q;
    assign sint      = sint_q;
`ifdef VGA_WB_B3_CTI_EN
    assign CTI_O     = cti_q;
    assign BTE_O     = 2'b00;
`endif

endmodule

// File: tb/tb_vga_wb_master.sv
// tb/tb_vga_wb_master.sv - randomized bench for vga_wb_master against a frame/page reference model
module tb_vga_wb_master;
    localparam int LCNT_W = 22;

    logic              CLK_I = 1'b0;
    logic              nRESET = 1'b0;
    logic              ven = 1'b0, vbsw = 1'b0, fifo_nfull = 1'b0;
    logic [1:0]        vbl = 2'd0;
    logic [29:0]       VBARa = '0, VBARb = '0;
    logic [LCNT_W-1:0] frame_len = LCNT_W'(1);
    logic [31:0]       DAT_I = '0;
    logic              ACK_I = 1'b0, ERR_I = 1'b0;
    logic              fifo_wreq, CYC_O, STB_O, WE_O, avmp, bsint, sint;
    logic [31:0]       fifo_d;
    logic [29:0]       ADR_O;
    logic [3:0]        SEL_O;
`ifdef VGA_WB_B3_CTI_EN
    logic [2:0]        CTI_O;
    logic [1:0]        BTE_O;
`endif

    vga_wb_master #(.LCNT_W(LCNT_W)) dut (
        .CLK_I(CLK_I), .nRESET(nRESET), .ven(ven), .vbsw(vbsw), .vbl(vbl),
        .VBARa(VBARa), .VBARb(VBARb), .frame_len(frame_len), .fifo_nfull(fifo_nfull),
        .fifo_wreq(fifo_wreq), .fifo_d(fifo_d), .ADR_O(ADR_O), .CYC_O(CYC_O),
        .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O),
`ifdef VGA_WB_B3_CTI_EN
        .CTI_O(CTI_O), .BTE_O(BTE_O),
`endif
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I),
        .avmp(avmp), .bsint(bsint), .sint(sint)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position in frame, current page, beats left in the open cycle.
    bit          exp_cyc, exp_wreq, exp_bsint, exp_sint, in_err;
    int          idx, page, left;
    logic [31:0] exp_d;
    // Slave policy and statistics.
    int          fixed_wait = 0, err_pct = 0, err_beat = 0, stray_pct = 0;
    int          wait_left = 0, beat_no = 0;
    int          wreq_cnt = 0, bsint_cnt = 0, sint_cnt = 0;
    logic [29:0] acc_adr[$];

    task automatic model_reset();
        exp_cyc = 0; exp_wreq = 0; exp_bsint = 0; exp_sint = 0; in_err = 0;
        idx = 0; page = 0; left = 0; wait_left = 0; beat_no = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, 32'(CYC_O), 0);
        check({tag, "_stb"}, 32'(STB_O), 0);
        check({tag, "_wreq"}, 32'(fifo_wreq), 0);
        check({tag, "_bsint"}, 32'(bsint), 0);
        check({tag, "_sint"}, 32'(sint), 0);
        check({tag, "_avmp"}, 32'(avmp), 0);
        check({tag, "_adr"}, 32'(ADR_O), 0);
        check({tag, "_fifo_d"}, fifo_d, 0);
    endtask

    // One clock: drive slave response, advance model for the coming edge, check at negedge.
    task automatic step();
        int          rem, blen;
        logic [29:0] ea;
        ACK_I = 0; ERR_I = 0; DAT_I = $urandom;
        if (CYC_O && STB_O) begin
            if (wait_left > 0) wait_left--;
            else begin
                beat_no++;
                if ((err_beat != 0 && beat_no == err_beat) || $urandom_range(0, 99) < err_pct) begin
                    ERR_I = 1; ACK_I = 1'($urandom_range(0, 1));
                end else begin
                    ACK_I = 1; acc_adr.push_back(ADR_O);
                end
                wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 2);
            end
        end else begin
            beat_no = 0;
            wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 2);
            if ($urandom_range(0, 99) < stray_pct) begin
                ACK_I = 1; ERR_I = 1'($urandom_range(0, 1));
            end
        end

        exp_wreq = 0; exp_bsint = 0; exp_sint = 0;
        if (exp_cyc) begin
            if (ERR_I) begin
                exp_cyc = 0; exp_sint = 1; in_err = 1;
            end else if (ACK_I) begin
                exp_wreq = 1; exp_d = DAT_I; idx++; left--;
                if (idx == int'(frame_len)) begin
                    idx = 0;
                    if (vbsw) begin page ^= 1; exp_bsint = 1; end
                end
                if (left == 0) exp_cyc = 0;
            end
        end else if (in_err) begin
            if (!ven) in_err = 0;
        end else if (!ven) begin
            idx = 0; page = 0;
        end else if (!fifo_nfull) begin
            exp_cyc = 1;
            blen = 1 << vbl;
            rem  = int'(frame_len) - idx;
            left = (blen < rem) ? blen : rem;
        end

        @(negedge CLK_I);
        check("cyc", 32'(CYC_O), 32'(exp_cyc));
        check("stb", 32'(STB_O), 32'(exp_cyc));
        check("wreq", 32'(fifo_wreq), 32'(exp_wreq));
        check("bsint", 32'(bsint), 32'(exp_bsint));
        check("sint", 32'(sint), 32'(exp_sint));
        check("avmp", 32'(avmp), 32'(page));
        check("we_sel", {27'd0, WE_O, SEL_O}, 32'h0000000f);
        if (exp_cyc) begin
            ea = (page != 0 ? VBARb : VBARa) + 30'(idx);
            check("adr", 32'(ADR_O), 32'(ea));
        end
        if (exp_wreq) check("fifo_d", fifo_d, exp_d);
`ifdef VGA_WB_B3_CTI_EN
        check("cti", 32'(CTI_O), exp_cyc ? ((left == 1) ? 32'd7 : 32'd2) : 32'd0);
        check("bte", 32'(BTE_O), 0);
`endif
        if (fifo_wreq) wreq_cnt++;
        if (bsint) bsint_cnt++;
        if (sint) sint_cnt++;
    endtask

    task automatic drain();
        int n = 0;
        ven = 0;
        while (exp_cyc && n < 100) begin step(); n++; end
        if (exp_cyc) check("drain_timeout", 0, 1);
        repeat (2) step();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge CLK_I);
        check_reset_outputs("por");
        nRESET = 1;
        model_reset();

        // Two 4-beat bursts per 8-word frame, then restart at VBARa.
        VBARa = 30'h100; VBARb = 30'h200; frame_len = LCNT_W'(8); vbl = 2'd2; fixed_wait = 0;
        repeat (2) step();
        acc_adr.delete(); wreq_cnt = 0; ven = 1;
        for (int i = 0; i < 200 && acc_adr.size() < 9; i++) step();
        check("burst_beats", acc_adr.size(), 9);
        for (int i = 0; i < 9; i++) check("burst_adr", 32'(acc_adr[i]), 32'h100 + 32'(i % 8));
        check("burst_wreq", wreq_cnt, 9);

        // 8-word burst truncated to a 6-word frame, one wait state per beat.
        drain();
        vbl = 2'd3; frame_len = LCNT_W'(6); fixed_wait = 1;
        step();
        acc_adr.delete(); ven = 1;
        for (int i = 0; i < 200 && acc_adr.size() < 7; i++) step();
        for (int i = 0; i < 7; i++) check("trunc_adr", 32'(acc_adr[i]), 32'h100 + 32'(i % 6));

        // Bank switching every 4-word frame.
        drain();
        vbsw = 1; VBARb = 30'h800; frame_len = LCNT_W'(4); vbl = 2'd2; fixed_wait = 0;
        step();
        acc_adr.delete(); bsint_cnt = 0; ven = 1;
        for (int i = 0; i < 200 && acc_adr.size() < 12; i++) step();
        for (int i = 0; i < 12; i++)
            check("bank_adr", 32'(acc_adr[i]), ((i / 4) % 2 == 1 ? 32'h800 : 32'h100) + 32'(i % 4));
        check("bank_bsint", bsint_cnt, 3);

        // Bus error on the second beat.
        drain();
        vbsw = 0; frame_len = LCNT_W'(8); err_beat = 2;
        step();
        wreq_cnt = 0; sint_cnt = 0; ven = 1;
        repeat (30) step();
        check("err_wreq", wreq_cnt, 1);
        check("err_sint", sint_cnt, 1);
        err_beat = 0; ven = 0;
        repeat (2) step();
        acc_adr.delete(); ven = 1;
        for (int i = 0; i < 20 && acc_adr.size() < 1; i++) step();
        check("err_restart_adr", 32'(acc_adr[0]), 32'h100);

        // Flow control holds off new cycles.
        drain();
        fifo_nfull = 1; ven = 1; n = 0;
        repeat (20) begin step(); if (CYC_O) n++; end
        check("flow_hold", n, 0);
        fifo_nfull = 0;
        step();
        check("flow_release", 32'(CYC_O), 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10 && !CYC_O; i++) step();
        #2 nRESET = 0;
        #1 check_reset_outputs("mid_rst");
        ven = 0; ACK_I = 0; ERR_I = 0;
        @(negedge CLK_I);
        nRESET = 1;
        model_reset();
        step();

        // Randomized segments.
        for (int seg = 0; seg < 8; seg++) begin
            drain();
            VBARa = 30'($urandom); VBARb = 30'($urandom);
            if (seg == 0) VBARa = 30'h3ffffffe;
            frame_len = LCNT_W'($urandom_range(1, 12));
            vbl = 2'($urandom_range(0, 3)); vbsw = 1'($urandom_range(0, 1));
            fixed_wait = -1; err_pct = 2; stray_pct = 10;
            step();
            ven = 1;
            repeat (300) begin
                fifo_nfull = ($urandom_range(0, 99) < 25);
                if ($urandom_range(0, 99) < 3) ven = ~ven;
                if ($urandom_range(0, 99) < 2) vbl = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) < 2) vbsw = ~vbsw;
                step();
            end
        end
        err_pct = 0; stray_pct = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_wb_master.md
Name: vga_wb_master

Overview:
- Wishbone read master for the VGA/LCD controller.
- Fetches pixel data from video memory in bursts, starting at the active bank base address (VBARa or VBARb), and pushes every returned word into the line FIFO.
- Performs video-memory bank switching at frame end and raises bank-switch and system-error interrupt pulses.
- These pulses drive the bsint_in and sint_in inputs of the register slave.

Parameters:
- LCNT_W, 22, width of the frame word counter and of frame_len.

Ports:
- CLK_I  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- ven  in  1  video enable
- vbsw  in  1  video memory bank switch enable
- vbl  in  2  burst length code: 00=1, 01=2, 10=4, 11=8 words
- VBARa  in  30  bank A base, word address [31:2]
- VBARb  in  30  bank B base, word address [31:2]
- frame_len  in  LCNT_W  words per frame; must be ≥1
- fifo_nfull  in  1  line FIFO nearly full; low guarantees room for 8 words
- fifo_wreq  out  1  FIFO write strobe
- fifo_d  out  32  FIFO write data
- ADR_O  out  30  Wishbone word address [31:2]
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  always 0
- SEL_O  out  4  always 4'b1111
- DAT_I  in  32  read data
- ACK_I  in  1  acknowledge
- ERR_I  in  1  bus error
- avmp  out  1  active video memory page: 0=A, 1=B
- bsint  out  1  bank-switch pulse, 1 cycle
- sint  out  1  system-error pulse, 1 cycle

Behaviour:
- Reset values: CYC_O=STB_O=fifo_wreq=bsint=sint=avmp=0; ADR_O=0; fifo_d=0; word counter=0; state IDLE.
- All outputs are registered.
- States and transitions:
  - IDLE: when ven=0, hold word_cnt=0 and avmp=0, and load ADR_O=VBARa continuously. When ven=1 and fifo_nfull=0, assert CYC_O/STB_O on the next edge, load burst_cnt = min(burst length, frame_len - word_cnt), go to BURST.
  - BURST: CYC_O/STB_O stay high until the last ACK_I. Wait states (ACK_I=0) hold all state. On each edge with ACK_I=1: fifo_wreq=1 and fifo_d=DAT_I on the next cycle (1-cycle latency), ADR_O+1, word_cnt+1, burst_cnt-1.
  - Last beat: the edge sampling the final ACK_I clears CYC_O/STB_O, so a combinational-ack slave cannot return an extra ACK. Go to IDLE; back-to-back bursts therefore have ≥1 idle cycle.
  - Frame end: if the last ACK completes word frame_len-1, then word_cnt=0. If vbsw=1: toggle avmp, pulse bsint, ADR_O = base of the new page. If vbsw=0: ADR_O = base of the current page.
  - Burst truncation: a burst never crosses frame end.
  - ERROR: entered on ERR_I=1 during BURST. CYC_O/STB_O drop on that edge, sint pulses 1 cycle, no fifo_wreq for that beat. Remain in ERROR while ven=1; ven=0 returns to IDLE.
- ACK_I and ERR_I both high: treat as ERR.
- ven falling mid-burst: the current burst completes normally, then IDLE with restart from VBARa.
- fifo_nfull is sampled only in IDLE; it never aborts a burst.
- ACK_I/ERR_I with CYC_O=0 are ignored.
- word_cnt and ADR_O wrap modulo their widths.

Optional Feature:
- Macro VGA_WB_B3_CTI_EN.
- Defined: adds outputs CTI_O[2:0] and BTE_O[1:0].
  - BTE_O=2'b00 (linear).
  - CTI_O=3'b010 on every beat except the last, 3'b111 on the last beat (also for single-word bursts).
  - Both are 0 when CYC_O=0.
- Undefined: ports absent; classic Wishbone cycles only; all other behaviour identical.

Test Plan:
- Reset: assert nRESET=0 mid-burst -> CYC_O, STB_O, fifo_wreq, bsint, sint, avmp all 0 immediately; ADR_O=0.
- Burst: ven=1, vbl=10, frame_len=8, VBARa=0x100, zero-wait ACK -> two 4-beat cycles at ADR_O 0x100–0x103 and 0x104–0x107; 8 fifo_wreq pulses carrying DAT_I; CYC_O low ≥1 cycle between bursts; then restart at 0x100.
- Truncation: vbl=11, frame_len=6, ACK with 1 wait state per beat -> one 6-beat cycle, no 7th ACK accepted, next cycle at VBARa.
- Bank switch: vbsw=1, VBARb=0x800, frame_len=4, vbl=10 -> after 4th ACK bsint=1 for exactly 1 cycle, avmp=1, next ADR_O=0x800; following frame returns to VBARa with avmp=0.
- Error: ERR_I=1 on 2nd beat -> CYC_O/STB_O low next cycle, sint 1-cycle pulse, 1 fifo_wreq total, no new cycle until ven=0 then 1 restarts at VBARa.
- Flow control: fifo_nfull=1 held 20 cycles -> CYC_O stays 0; release -> CYC_O=1 on the next edge.
